spi_slave_tx_fifo: RTL

SPI_SLAVE_TX_FIFO -- requirements
Module: spi_slave_tx_fifo

---
 rtl/spi_slave_tx_fifo_if.sv | 45 ++++
 rtl/spi_slave_tx_fifo.sv | 82 ++++++++
 2 files changed

// File: rtl/spi_slave_tx_fifo_if.sv
// ============================================================================
// spi_slave_tx_fifo_if : write/read handshake bundle for spi_slave_tx_fifo
// Revision: 1.0
// ============================================================================
`default_nettype none

interface spi_slave_tx_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic                  flush;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [c_CNT_W-1:0]    elements;

  modport slave (
    input  flush,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output elements
  );

  modport master (
    output flush,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  elements
  );
endinterface

`default_nettype wire

// File: rtl/spi_slave_tx_fifo.sv
// ============================================================================
// spi_slave_tx_fifo : show-ahead word FIFO between AXI plug reads and SPI TX.
// Optional macro SPI_SLAVE_TX_FIFO_FLUSH_EN enables the flush input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_slave_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  wire logic         axi_aclk,
  input  wire logic         axi_areset,
  spi_slave_tx_fifo_if.slave bus
);
  localparam int               c_AW   = $clog2(DEPTH);
  localparam int               c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_CW-1:0]       r_count;

  logic w_flush;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

`ifdef SPI_SLAVE_TX_FIFO_FLUSH_EN
  assign w_flush = bus.flush;
`else
  // Port kept for pin compatibility; its value has no effect in this build.
  wire w_unused_flush = bus.flush;
  assign w_flush = 1'b0;
`endif

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  assign bus.in_ready  = !w_full && !w_flush;
  assign bus.out_valid = !w_empty;
  assign bus.elements  = r_count;
  // Head word is forced to zero when empty so stale storage never leaks out.
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end
endmodule

`default_nettype wire
